// File: rtl/fill_write_responder_if.sv
// AXI write channels plus DRAM write port and status counters for fill_write_responder.
interface fill_write_responder_if #(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic [ID_W-1:0]   awid_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic              awvalid_i;
  logic              awready_o;
  logic [ID_W-1:0]   wid_i;
  logic [DATA_W-1:0] wdata_i;
  logic              wvalid_i;
  logic              wready_o;
  logic [ID_W-1:0]   bid_o;
  logic [1:0]        bresp_o;
  logic              bvalid_o;
  logic              bready_i;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ready_i;
  logic [31:0]       ok_cnt_o;
  logic [31:0]       err_cnt_o;

  modport slave (
    input  awid_i, awaddr_i, awvalid_i, wid_i, wdata_i, wvalid_i, bready_i, mem_ready_i,
    output awready_o, wready_o, bid_o, bresp_o, bvalid_o, mem_wr_o, mem_addr_o, mem_data_o,
           ok_cnt_o, err_cnt_o
  );

  modport master (
    output awid_i, awaddr_i, awvalid_i, wid_i, wdata_i, wvalid_i, bready_i, mem_ready_i,
    input  awready_o, wready_o, bid_o, bresp_o, bvalid_o, mem_wr_o, mem_addr_o, mem_data_o,
           ok_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/fill_write_responder.sv
// Pairs AXI AW and W beats in order, writes good pairs to DRAM and returns one B per pair.
module fill_write_responder #(
  parameter int                ID_W      = 16,
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 512,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(64'h1_0000_0000)
) (
  input  logic                   clk,
  input  logic                   rst,
  fill_write_responder_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [ID_W-1:0]   aw_id_q   [DEPTH];
  logic [ADDR_W-1:0] aw_addr_q [DEPTH];
  logic [ID_W-1:0]   w_id_q    [DEPTH];
  logic [DATA_W-1:0] w_data_q  [DEPTH];
  logic [ID_W-1:0]   b_id_q    [DEPTH];
  logic [1:0]        b_resp_q  [DEPTH];

  ptr_t aw_wr, aw_rd, w_wr, w_rd, b_wr, b_rd;
  cnt_t aw_count, w_count, b_count;

  state_t            state, state_nx;
  logic [ID_W-1:0]   pair_id;
  logic [ADDR_W-1:0] pair_addr;
  logic [DATA_W-1:0] pair_data;
  logic [31:0]       ok_cnt, err_cnt;

  logic            aw_push, w_push, b_pop, pair_pop, b_push;
  logic [ID_W-1:0] b_push_id;
  logic [1:0]      b_push_resp;

  // Readiness comes only from registered counts, so a pop never frees a slot in the same cycle.
  assign bus.awready_o = (aw_count != cnt_t'(DEPTH));
  assign bus.wready_o  = (w_count != cnt_t'(DEPTH));
  assign aw_push       = bus.awvalid_i & bus.awready_o;
  assign w_push        = bus.wvalid_i & bus.wready_o;

  assign bus.bvalid_o   = (b_count != '0);
  assign b_pop          = bus.bvalid_o & bus.bready_i;
  assign bus.bid_o      = bus.bvalid_o ? b_id_q[b_rd] : '0;
  assign bus.bresp_o    = bus.bvalid_o ? b_resp_q[b_rd] : 2'b00;
  assign bus.mem_wr_o   = (state == ISSUE);
  assign bus.mem_addr_o = pair_addr;
  assign bus.mem_data_o = pair_data;
  assign bus.ok_cnt_o   = ok_cnt;
  assign bus.err_cnt_o  = err_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A pair is only popped when the B queue can take its response; errors answer immediately.
  always_comb begin
    state_nx    = state;
    pair_pop    = 1'b0;
    b_push      = 1'b0;
    b_push_id   = pair_id;
    b_push_resp = RESP_OKAY;
    case (state)
      IDLE: begin
        if ((aw_count != '0) && (w_count != '0) && (b_count < cnt_t'(DEPTH))) begin
          pair_pop  = 1'b1;
          b_push_id = aw_id_q[aw_rd];
          if (w_id_q[w_rd] != aw_id_q[aw_rd]) begin
            b_push      = 1'b1;
            b_push_resp = RESP_SLVERR;
          end else if (aw_addr_q[aw_rd] >= MEM_LIMIT) begin
            b_push      = 1'b1;
            b_push_resp = RESP_DECERR;
          end else begin
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ready_i) begin
          b_push   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_wr <= '0; aw_rd <= '0; aw_count <= '0;
      w_wr  <= '0; w_rd  <= '0; w_count  <= '0;
      b_wr  <= '0; b_rd  <= '0; b_count  <= '0;
      pair_id <= '0; pair_addr <= '0; pair_data <= '0;
      ok_cnt  <= '0; err_cnt <= '0;
    end else begin
      if (aw_push)  aw_wr <= aw_wr + ptr_t'(1);
      if (w_push)   w_wr  <= w_wr + ptr_t'(1);
      if (b_push)   b_wr  <= b_wr + ptr_t'(1);
      if (b_pop)    b_rd  <= b_rd + ptr_t'(1);
      if (pair_pop) begin
        aw_rd     <= aw_rd + ptr_t'(1);
        w_rd      <= w_rd + ptr_t'(1);
        pair_id   <= aw_id_q[aw_rd];
        pair_addr <= aw_addr_q[aw_rd];
        pair_data <= w_data_q[w_rd];
      end
      aw_count <= aw_count + cnt_t'(aw_push) - cnt_t'(pair_pop);
      w_count  <= w_count + cnt_t'(w_push) - cnt_t'(pair_pop);
      b_count  <= b_count + cnt_t'(b_push) - cnt_t'(b_pop);
      if (b_push && (b_push_resp == RESP_OKAY)) ok_cnt  <= ok_cnt + 32'd1;
      if (b_push && (b_push_resp != RESP_OKAY)) err_cnt <= err_cnt + 32'd1;
    end
  end

  // Queue storage needs no reset: nothing is read until its count says it is valid.
  always_ff @(posedge clk) begin
    if (aw_push) begin
      aw_id_q[aw_wr]   <= bus.awid_i;
      aw_addr_q[aw_wr] <= bus.awaddr_i;
    end
    if (w_push) begin
      w_id_q[w_wr]   <= bus.wid_i;
      w_data_q[w_wr] <= bus.wdata_i;
    end
    if (b_push) begin
      b_id_q[b_wr]   <= b_push_id;
      b_resp_q[b_wr] <= b_push_resp;
    end
  end
endmodule
